// File: rtl/pwm_pattern_sequencer.sv
// pwm_pattern_sequencer
//   Plays a programmable table of up to 8 {level, duration} segments on a
//   3-bit output. Each segment holds its level for max(secs,1) one-second
//   ticks, where one tick is CLK_HZ clock cycles. A sequence runs once and
//   ends with a one-cycle done pulse, or repeats when looping is enabled.
//
// Build option:
//   PWM_SEQ_LOOP_EN  defined   -> the loop input repeats the sequence
//                    undefined -> every sequence is one-shot; loop is ignored
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   wr_en      table write strobe (accepted in any state)
//   wr_addr    table entry to write
//   wr_level   entry output level, one bit per opin channel
//   wr_secs    entry duration in seconds (0 behaves as 1)
//   seg_count  number of active segments, 1..8, sampled at start and at
//              every segment end
//   start      begin a sequence while idle
//   stop       abort a running sequence (no done pulse)
//   loop       repeat after the last segment
//   opin       registered pattern outputs
//   busy       high while a sequence is running
//   seg_idx    index of the segment being played
//   done       one-cycle pulse when the last segment ends
module pwm_pattern_sequencer #(
  parameter int CLK_HZ  = 27000000,
  parameter int NUM_SEG = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [2:0] wr_level,
  input  logic [3:0] wr_secs,
  input  logic [3:0] seg_count,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [2:0] opin,
  output logic       busy,
  output logic [2:0] seg_idx,
  output logic       done
);

  localparam int              PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_SEG - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [3:0]    sec_cnt;
  logic [2:0]    lvl_tab  [NUM_SEG];
  logic [3:0]    secs_tab [NUM_SEG];

  logic       tick;
  logic       seg_end;
  logic       last_seg;
  logic       loop_en;
  logic       start_ok;
  logic [2:0] next_idx;
  logic [3:0] idx_plus1;

  // A zero duration is played as one second.
  function automatic logic [3:0] min1(input logic [3:0] s);
    return (s == 4'd0) ? 4'd1 : s;
  endfunction

  // sec_cnt holds the seconds still to play in the current segment,
  // including the one in progress, so the segment ends on the tick that
  // finds it at 1.
  assign tick      = (prescaler == PRE_MAX);
  assign seg_end   = tick && (sec_cnt <= 4'd1);
  assign idx_plus1 = {1'b0, seg_idx} + 4'd1;
  assign next_idx  = seg_idx + 3'd1;
  // The last entry of the table always ends the pass, even if seg_count
  // was raised out of range while running.
  assign last_seg  = (seg_count <= idx_plus1) || (seg_idx == LAST_IDX);
  assign start_ok  = start && !stop && (seg_count >= 4'd1) && (seg_count <= 4'd8);

`ifdef PWM_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  // One-shot build: the port stays for pin compatibility but has no effect.
  assign loop_en = loop & 1'b0;
`endif

  // Pattern table; entries are only read when their segment is loaded, so
  // rewriting the playing entry takes effect on its next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        lvl_tab[i]  <= 3'd0;
        secs_tab[i] <= 4'd1;
      end
    end else if (wr_en) begin
      lvl_tab[wr_addr]  <= wr_level;
      secs_tab[wr_addr] <= wr_secs;
    end
  end

  // Sequencer FSM; stop wins over segment end, and start is only looked at
  // while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      opin      <= 3'd0;
      seg_idx   <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      prescaler <= '0;
      sec_cnt   <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= RUN;
            busy      <= 1'b1;
            seg_idx   <= 3'd0;
            opin      <= lvl_tab[0];
            prescaler <= '0;
            sec_cnt   <= min1(secs_tab[0]);
          end
        end
        RUN: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            opin      <= 3'd0;
            seg_idx   <= 3'd0;
            prescaler <= '0;
            sec_cnt   <= 4'd0;
          end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) sec_cnt <= sec_cnt - 4'd1;
            if (seg_end) begin
              if (!last_seg) begin
                seg_idx <= next_idx;
                opin    <= lvl_tab[next_idx];
                sec_cnt <= min1(secs_tab[next_idx]);
              end else if (loop_en) begin
                seg_idx <= 3'd0;
                opin    <= lvl_tab[0];
                sec_cnt <= min1(secs_tab[0]);
                done    <= 1'b1;
              end else begin
                state   <= IDLE;
                busy    <= 1'b0;
                opin    <= 3'd0;
                seg_idx <= 3'd0;
                sec_cnt <= 4'd0;
                done    <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
